register_operand_stage: RTL and testbench

- Operand-fetch stage directly upstream of the register-type ALU.
- Accepts a 32-bit instruction word and splits it into opcode, subfunction_3 and subfunction_7.
- Reads rs1/rs2 from an internal 32x32 integer register file and presents them to the ALU through a one-entry output buffer with a valid/ready handshake.
- Owns the register-file write port used by writeback.

---
 rtl/register_operand_stage.sv | 133 +++++++++++++
 tb/tb_register_operand_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_operand_stage.sv
// Operand-fetch stage: decodes an RV32 instruction, reads rs1/rs2 from the
// integer register file and holds them in a one-entry valid/ready buffer.
module register_operand_stage #(
    parameter int          REGISTER_COUNT = 32,
    parameter logic [31:0] RESET_VALUE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instruction_valid,
    input  logic [31:0] instruction,
    output logic        instruction_ready,
    output logic        operands_valid,
    input  logic        operands_ready,
    output logic [6:0]  opcode,
    output logic [2:0]  subfunction_3,
    output logic [6:0]  subfunction_7,
    output logic [4:0]  destination_register,
    output logic [31:0] input_register1_value,
    output logic [31:0] input_register2_value,
    input  logic        write_enable,
    input  logic [4:0]  write_register,
    input  logic [31:0] write_value
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [31:0] regs [REGISTER_COUNT];

    logic [6:0]  opcode_reg;
    logic [2:0]  funct3_reg;
    logic [6:0]  funct7_reg;
    logic [4:0]  rd_reg;
    logic [4:0]  rs1_reg, rs2_reg;
    logic [31:0] op1_reg, op2_reg;

    logic        accept;
    logic        write_live;
    logic [4:0]  rs1_index, rs2_index;
    logic [31:0] rs1_fetch, rs2_fetch;
    logic        snoop1, snoop2;

    assign accept     = instruction_valid && instruction_ready;
    assign write_live = write_enable && (write_register != 5'd0);
    assign rs1_index  = instruction[19:15];
    assign rs2_index  = instruction[24:20];

    // A write landing on the same edge as the read wins over the stored value.
    always_comb begin
        rs1_fetch = regs[rs1_index];
        rs2_fetch = regs[rs2_index];
        if (write_live && (write_register == rs1_index))
            rs1_fetch = write_value;
        if (write_live && (write_register == rs2_index))
            rs2_fetch = write_value;
        if (rs1_index == 5'd0)
            rs1_fetch = '0;
        if (rs2_index == 5'd0)
            rs2_fetch = '0;
    end

    assign snoop1 = (state_reg == FULL) && !accept && write_live && (write_register == rs1_reg);
    assign snoop2 = (state_reg == FULL) && !accept && write_live && (write_register == rs2_reg);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n)
            state_reg <= EMPTY;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (operands_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        operands_valid    = (state_reg == FULL);
        instruction_ready = (state_reg == EMPTY) || operands_ready;
    end

    // Register file; index 0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs[0] <= '0;
            for (int i = 1; i < REGISTER_COUNT; i++)
                regs[i] <= RESET_VALUE;
        end else if (write_live) begin
            regs[write_register] <= write_value;
        end
    end

    // Output buffer with snooping of writes to the buffered source indices.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opcode_reg <= '0;
            funct3_reg <= '0;
            funct7_reg <= '0;
            rd_reg     <= '0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            op1_reg    <= '0;
            op2_reg    <= '0;
        end else if (accept) begin
            opcode_reg <= instruction[6:0];
            funct3_reg <= instruction[14:12];
            funct7_reg <= instruction[31:25];
            rd_reg     <= instruction[11:7];
            rs1_reg    <= rs1_index;
            rs2_reg    <= rs2_index;
            op1_reg    <= rs1_fetch;
            op2_reg    <= rs2_fetch;
        end else begin
            if (snoop1) op1_reg <= write_value;
            if (snoop2) op2_reg <= write_value;
        end
    end

    assign opcode                = opcode_reg;
    assign subfunction_3         = funct3_reg;
    assign subfunction_7         = funct7_reg;
    assign destination_register  = rd_reg;
    assign input_register1_value = op1_reg;
    assign input_register2_value = op2_reg;

endmodule

// File: tb/tb_register_operand_stage.sv
// Directed bench for register_operand_stage: reset, x0, bypass, stall/snoop,
// streaming and mid-operation reset, each checked with immediate assertions.
module tb_register_operand_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic        instruction_ready;
    logic        operands_valid;
    logic        operands_ready;
    logic [6:0]  opcode;
    logic [2:0]  subfunction_3;
    logic [6:0]  subfunction_7;
    logic [4:0]  destination_register;
    logic [31:0] input_register1_value;
    logic [31:0] input_register2_value;
    logic        write_enable;
    logic [4:0]  write_register;
    logic [31:0] write_value;

    int errors = 0;
    int checks = 0;

    register_operand_stage dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .instruction_valid     (instruction_valid),
        .instruction           (instruction),
        .instruction_ready     (instruction_ready),
        .operands_valid        (operands_valid),
        .operands_ready        (operands_ready),
        .opcode                (opcode),
        .subfunction_3         (subfunction_3),
        .subfunction_7         (subfunction_7),
        .destination_register  (destination_register),
        .input_register1_value (input_register1_value),
        .input_register2_value (input_register2_value),
        .write_enable          (write_enable),
        .write_register        (write_register),
        .write_value           (write_value)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic set_write(input logic en, input logic [4:0] idx, input logic [31:0] val);
        write_enable   = en;
        write_register = idx;
        write_value    = val;
    endtask

    // Register contents the bench has written before the streaming phase.
    function automatic logic [31:0] model_reg(input logic [4:0] idx);
        case (idx)
            5'd2:    return 32'h0000_00AA;
            5'd4:    return 32'h0000_0044;
            5'd5:    return 32'h1234_5678;
            5'd7:    return 32'hDEAD_BEEF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    initial begin
        logic [4:0] rs1_tab [8];
        logic [4:0] rs2_tab [8];
        logic [4:0] rd_v;
        logic [2:0] f3_v;
        logic [6:0] f7_v;

        rs1_tab = '{5'd5, 5'd7, 5'd2, 5'd4, 5'd0, 5'd5, 5'd7, 5'd2};
        rs2_tab = '{5'd4, 5'd2, 5'd7, 5'd5, 5'd5, 5'd0, 5'd7, 5'd4};

        reset_n           = 1'b0;
        instruction_valid = 1'b0;
        instruction       = 32'h0;
        operands_ready    = 1'b0;
        set_write(1'b0, 5'd0, 32'h0);

        // Reset held for two edges
        tick();
        tick();
        check("reset_valid", {31'b0, operands_valid}, 32'd0);
        check("reset_ready", {31'b0, instruction_ready}, 32'd1);
        check("reset_opcode", {25'b0, opcode}, 32'd0);
        check("reset_op1", input_register1_value, 32'h0);

        // Write x5, then ADD x3,x5,x0
        reset_n = 1'b1;
        set_write(1'b1, 5'd5, 32'h1234_5678);
        tick();
        set_write(1'b0, 5'd0, 32'h0);
        instruction_valid = 1'b1;
        instruction       = 32'h0002_81B3;
        tick();
        instruction_valid = 1'b0;
        check("add_valid", {31'b0, operands_valid}, 32'd1);
        check("add_op1", input_register1_value, 32'h1234_5678);
        check("add_op2", input_register2_value, 32'h0);
        check("add_opcode", {25'b0, opcode}, 32'h33);
        check("add_rd", {27'b0, destination_register}, 32'd3);
        check("full_stall_ready", {31'b0, instruction_ready}, 32'd0);

        // Write to x0 while draining; then read x0/x0
        operands_ready = 1'b1;
        set_write(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        set_write(1'b0, 5'd0, 32'h0);
        check("drain_valid", {31'b0, operands_valid}, 32'd0);
        instruction_valid = 1'b1;
        instruction       = 32'h0000_00B3;
        tick();
        check("x0_op1", input_register1_value, 32'h0);
        check("x0_op2", input_register2_value, 32'h0);
        check("x0_rd", {27'b0, destination_register}, 32'd1);

        // Same-edge bypass: write x7 and accept SUB x1,x7,x7
        set_write(1'b1, 5'd7, 32'hDEAD_BEEF);
        instruction = 32'h4073_80B3;
        tick();
        set_write(1'b0, 5'd0, 32'h0);
        instruction_valid = 1'b0;
        check("bypass_op1", input_register1_value, 32'hDEAD_BEEF);
        check("bypass_op2", input_register2_value, 32'hDEAD_BEEF);
        check("bypass_f7", {25'b0, subfunction_7}, 32'h20);
        check("bypass_valid", {31'b0, operands_valid}, 32'd1);

        // Drain while writing x4, then fill with ADD x6,x2,x4 under backpressure
        set_write(1'b1, 5'd4, 32'h0000_0044);
        tick();
        set_write(1'b0, 5'd0, 32'h0);
        operands_ready    = 1'b0;
        instruction_valid = 1'b1;
        instruction       = 32'h0041_0333;
        tick();
        instruction = 32'hFFFF_FFFF;
        check("stall1_ready", {31'b0, instruction_ready}, 32'd0);
        check("stall1_op1", input_register1_value, 32'h0);
        check("stall1_op2", input_register2_value, 32'h44);
        tick();
        check("stall2_ready", {31'b0, instruction_ready}, 32'd0);
        set_write(1'b1, 5'd2, 32'h0000_00AA);
        tick();
        set_write(1'b0, 5'd0, 32'h0);
        check("snoop_op1", input_register1_value, 32'hAA);
        check("snoop_op2", input_register2_value, 32'h44);
        check("snoop_opcode", {25'b0, opcode}, 32'h33);
        check("snoop_rd", {27'b0, destination_register}, 32'd6);
        check("snoop_valid", {31'b0, operands_valid}, 32'd1);
        check("stall3_ready", {31'b0, instruction_ready}, 32'd0);
        tick();
        check("stall_hold_op1", input_register1_value, 32'hAA);
        check("stall_hold_opcode", {25'b0, opcode}, 32'h33);
        check("stall_hold_f7", {25'b0, subfunction_7}, 32'h00);
        instruction_valid = 1'b0;
        operands_ready    = 1'b1;
        tick();
        check("stall_drain_valid", {31'b0, operands_valid}, 32'd0);

        // Streaming: eight back-to-back instructions
        instruction_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_v = 5'(i + 8);
            f3_v = 3'(i);
            f7_v = i[0] ? 7'h20 : 7'h00;
            instruction = {f7_v, rs2_tab[i], rs1_tab[i], f3_v, rd_v, 7'h33};
            check($sformatf("stream%0d_ready", i), {31'b0, instruction_ready}, 32'd1);
            tick();
            check($sformatf("stream%0d_valid", i), {31'b0, operands_valid}, 32'd1);
            check($sformatf("stream%0d_op1", i), input_register1_value, model_reg(rs1_tab[i]));
            check($sformatf("stream%0d_op2", i), input_register2_value, model_reg(rs2_tab[i]));
            check($sformatf("stream%0d_rd", i), {27'b0, destination_register}, {27'b0, rd_v});
            check($sformatf("stream%0d_f3", i), {29'b0, subfunction_3}, {29'b0, f3_v});
            check($sformatf("stream%0d_f7", i), {25'b0, subfunction_7}, {25'b0, f7_v});
        end
        instruction_valid = 1'b0;
        tick();
        check("stream_end_valid", {31'b0, operands_valid}, 32'd0);

        // Mid-operation reset with the buffer full and stalled
        set_write(1'b1, 5'd9, 32'h9999_9999);
        tick();
        set_write(1'b0, 5'd0, 32'h0);
        operands_ready    = 1'b0;
        instruction_valid = 1'b1;
        instruction       = 32'h0054_8533;
        tick();
        check("prereset_op1", input_register1_value, 32'h9999_9999);
        check("prereset_op2", input_register2_value, 32'h1234_5678);
        reset_n     = 1'b0;
        instruction = 32'h0000_00B3;
        set_write(1'b1, 5'd9, 32'h0000_0055);
        tick();
        reset_n = 1'b1;
        set_write(1'b0, 5'd0, 32'h0);
        instruction_valid = 1'b0;
        check("midreset_valid", {31'b0, operands_valid}, 32'd0);
        check("midreset_opcode", {25'b0, opcode}, 32'd0);
        check("midreset_rd", {27'b0, destination_register}, 32'd0);
        check("midreset_op1", input_register1_value, 32'h0);
        check("midreset_op2", input_register2_value, 32'h0);
        check("midreset_ready", {31'b0, instruction_ready}, 32'd1);
        instruction_valid = 1'b1;
        instruction       = 32'h0074_80B3;
        tick();
        instruction_valid = 1'b0;
        check("postreset_valid", {31'b0, operands_valid}, 32'd1);
        check("postreset_x9", input_register1_value, 32'h0);
        check("postreset_x7", input_register2_value, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
